// File: rtl/fp_alu_dispatcher.sv
// Command FIFO and sequencer in front of a shared FP ALU. It keeps one operation in flight,
// returns responses in command order, and aborts the operation if the ALU never answers.
//
// state       | meaning
// S_IDLE      | wait for a queued command and a ready ALU
// S_ISSUE     | one-cycle alu_start pulse
// S_WAIT_BUSY | wait for the ALU to acknowledge by dropping alu_ready
// S_WAIT_DONE | wait for alu_ready to return with the result
// S_RESP      | hold the response until rsp_ready
module fp_alu_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    input  logic [2:0]  cmd_op,
    input  logic [3:0]  cmd_tag,
    output logic        alu_start,
    output logic [31:0] alu_operand_a,
    output logic [31:0] alu_operand_b,
    output logic [2:0]  alu_opcode,
    input  logic        alu_ready,
    input  logic [31:0] alu_result,
    input  logic        alu_invalid,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_invalid,
    output logic [3:0]  rsp_tag,
    output logic        err_timeout,
    output logic        busy
);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW1 = AW + 1;
    localparam int CW  = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   FULL = AW1'(DEPTH);
    localparam logic [CW-1:0] TMO  = CW'(TIMEOUT);
    localparam logic [31:0]   QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic [31:0]   fifo_a   [DEPTH];
    logic [31:0]   fifo_b   [DEPTH];
    logic [2:0]    fifo_op  [DEPTH];
    logic [3:0]    fifo_tag [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic [31:0]   hold_a, hold_b;
    logic [2:0]    hold_op;
    logic [3:0]    hold_tag;

    logic [CW-1:0] cyc_cnt, cyc_inc;
    logic          tmo_hit;
    logic          push, pop, capture, abort;

    assign cmd_ready     = (count != FULL);
    assign push          = cmd_valid && cmd_ready;
    assign cyc_inc       = cyc_cnt + CW'(1);
    assign tmo_hit       = (cyc_inc >= TMO);
    assign alu_operand_a = hold_a;
    assign alu_operand_b = hold_b;
    assign alu_opcode    = hold_op;
    assign rsp_valid     = (state == S_RESP);
    assign busy          = (count != '0) || (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        alu_start = 1'b0;
        pop       = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;
        case (state)
            S_IDLE: begin
                if ((count != '0) && alu_ready) begin
                    pop       = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                alu_start = 1'b1;
                state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // the watchdog wins so a counter at its limit can never enter WAIT_DONE
                if (tmo_hit) begin
                    abort     = 1'b1;
                    state_nxt = S_RESP;
                end else if (!alu_ready) begin
                    state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (alu_ready) begin
                    capture   = 1'b1;
                    state_nxt = S_RESP;
                end else if (tmo_hit) begin
                    abort     = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr]   <= cmd_a;
            fifo_b[wr_ptr]   <= cmd_b;
            fifo_op[wr_ptr]  <= cmd_op;
            fifo_tag[wr_ptr] <= cmd_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            cyc_cnt     <= '0;
            hold_a      <= '0;
            hold_b      <= '0;
            hold_op     <= '0;
            hold_tag    <= '0;
            rsp_result  <= '0;
            rsp_invalid <= 1'b0;
            rsp_tag     <= '0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + AW1'(1);
            else if (pop && !push) count <= count - AW1'(1);

            if (pop) begin
                hold_a   <= fifo_a[rd_ptr];
                hold_b   <= fifo_b[rd_ptr];
                hold_op  <= fifo_op[rd_ptr];
                hold_tag <= fifo_tag[rd_ptr];
            end

            if (state == S_ISSUE)
                cyc_cnt <= '0;
            else if ((state == S_WAIT_BUSY) || (state == S_WAIT_DONE))
                cyc_cnt <= cyc_inc;

            if (capture) begin
                rsp_result  <= alu_result;
                rsp_invalid <= alu_invalid;
                rsp_tag     <= hold_tag;
            end else if (abort) begin
                rsp_result  <= QNAN;
                rsp_invalid <= 1'b1;
                rsp_tag     <= hold_tag;
                err_timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fp_alu_dispatcher.sv
// Bench for fp_alu_dispatcher: behavioural ALU stub, an in-order queue of expected responses,
// and directed scenarios (single op, divide by zero, random traffic, fill, backpressure, timeout, reset).
module tb_fp_alu_dispatcher;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 32;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic [31:0] res;
        logic        inv;
        logic [3:0]  tag;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a, cmd_b;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_tag;
    logic        alu_start;
    logic [31:0] alu_operand_a, alu_operand_b;
    logic [2:0]  alu_opcode;
    logic        alu_ready;
    logic [31:0] alu_result;
    logic        alu_invalid;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_invalid;
    logic [3:0]  rsp_tag;
    logic        err_timeout;
    logic        busy;

    fp_alu_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_start(alu_start), .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
        .alu_opcode(alu_opcode), .alu_ready(alu_ready), .alu_result(alu_result),
        .alu_invalid(alu_invalid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_invalid(rsp_invalid), .rsp_tag(rsp_tag),
        .err_timeout(err_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // controls written only by the main sequence
    bit alu_hang, alu_hold;
    int lat_min, lat_max, kill_req;
    bit bp_mode, bp_level;

    // ALU stub state, written only by the stub
    bit          alu_active;
    int          alu_left, kill_seen;
    int          starts, last_start_cyc;
    logic [31:0] m_r;
    logic        m_inv;

    // responses seen on the bus, written only by the monitor
    rsp_t obs_q[$];
    int   last_hs_cyc;

    rsp_t exp_q[$];
    int   chk_idx = 0;

    // ALU behaviour; 1.0+2.0 is given its true IEEE sum, other ops are a fixed scramble
    function automatic void alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                   output logic [31:0] r, output logic inv);
        inv = 1'b0;
        case (op)
            3'd0: r = (a == 32'h3F80_0000 && b == 32'h4000_0000) ? 32'h4040_0000 : a + b;
            3'd1: r = a - b;
            3'd2: r = a * b;
            3'd3: begin
                if (b[30:0] == 31'd0) begin
                    r   = QNAN;
                    inv = 1'b1;
                end else begin
                    r = a ^ {b[15:0], b[31:16]};
                end
            end
            default: begin
                r   = QNAN;
                inv = 1'b1;
            end
        endcase
    endfunction

    initial begin
        alu_ready   = 1'b1;
        alu_result  = '0;
        alu_invalid = 1'b0;
        alu_active  = 1'b0;
        alu_left    = 0;
        kill_seen   = 0;
        starts      = 0;
        last_start_cyc = 0;
        forever begin
            @(posedge clk); #1;
            if (alu_start) begin
                starts++;
                last_start_cyc = cyc;
            end
            if (kill_seen != kill_req) begin
                kill_seen  = kill_req;
                alu_active = 1'b0;
                alu_ready  = 1'b1;
            end else if (alu_active) begin
                if (alu_left > 0) begin
                    alu_left--;
                end else if (!alu_hang) begin
                    // operands are read at completion, long after the start pulse
                    alu_fn(alu_operand_a, alu_operand_b, alu_opcode, m_r, m_inv);
                    alu_result  = m_r;
                    alu_invalid = m_inv;
                    alu_ready   = 1'b1;
                    alu_active  = 1'b0;
                end
            end else if (alu_start) begin
                alu_active  = 1'b1;
                alu_left    = $urandom_range(lat_max, lat_min);
                alu_ready   = 1'b0;
                alu_result  = $urandom;
                alu_invalid = 1'b0;
            end else begin
                alu_ready = !alu_hold;
            end
        end
    end

    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            rsp_ready = bp_mode ? ($urandom_range(3, 0) != 0) : bp_level;
        end
    end

    initial begin
        last_hs_cyc = 0;
        forever begin
            @(negedge clk);
            if (!reset && rsp_valid && rsp_ready) begin
                obs_q.push_back('{res: rsp_result, inv: rsp_invalid, tag: rsp_tag});
                last_hs_cyc = cyc;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%h expected=0x%h", name, obs, exp);
        end
    endtask

    task automatic check_rsps();
        while (chk_idx < obs_q.size()) begin
            if (chk_idx < exp_q.size()) begin
                check("rsp_result",  obs_q[chk_idx].res,       exp_q[chk_idx].res);
                check("rsp_invalid", 32'(obs_q[chk_idx].inv),  32'(exp_q[chk_idx].inv));
                check("rsp_tag",     32'(obs_q[chk_idx].tag),  32'(exp_q[chk_idx].tag));
            end else begin
                check("rsp_extra", 32'(obs_q.size()), 32'(exp_q.size()));
            end
            chk_idx++;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_cmd_ready"},   32'(cmd_ready),     32'd1);
        check({name, "_alu_start"},   32'(alu_start),     32'd0);
        check({name, "_operand_a"},   alu_operand_a,      32'd0);
        check({name, "_operand_b"},   alu_operand_b,      32'd0);
        check({name, "_opcode"},      32'(alu_opcode),    32'd0);
        check({name, "_rsp_valid"},   32'(rsp_valid),     32'd0);
        check({name, "_rsp_result"},  rsp_result,         32'd0);
        check({name, "_rsp_invalid"}, 32'(rsp_invalid),   32'd0);
        check({name, "_rsp_tag"},     32'(rsp_tag),       32'd0);
        check({name, "_err_timeout"}, 32'(err_timeout),   32'd0);
        check({name, "_busy"},        32'(busy),          32'd0);
    endtask

    // all sequence tasks start and end one time unit after a rising edge
    task automatic push_cmd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                            input logic [3:0] tag, input int max_wait, output bit ok);
        rsp_t        e;
        logic [31:0] r;
        logic        inv;
        ok        = 1'b0;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_tag   = tag;
        cmd_valid = 1'b1;
        for (int i = 0; i < max_wait && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                if (alu_hang) begin
                    r   = QNAN;
                    inv = 1'b1;
                end else begin
                    alu_fn(a, b, op, r, inv);
                end
                e.res = r;
                e.inv = inv;
                e.tag = tag;
                exp_q.push_back(e);
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int budget, input string name);
        bit got = (obs_q.size() >= target);
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk); #1;
            got = (obs_q.size() >= target);
        end
        check(name, 32'(got), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk); #1;
            done = !busy && (obs_q.size() >= exp_q.size());
        end
        check(name, 32'(done), 32'd1);
        check_rsps();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        kill_req++;
        while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
    endtask

    initial begin
        bit ok, got;
        int n0, s0, hs;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = '0;
        cmd_tag   = '0;
        alu_hang  = 1'b0;
        alu_hold  = 1'b0;
        lat_min   = 1;
        lat_max   = 6;
        kill_req  = 0;
        bp_mode   = 1'b0;
        bp_level  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_outputs("por");

        // single add 1.0 + 2.0
        n0 = obs_q.size();
        s0 = starts;
        push_cmd(32'h3F80_0000, 32'h4000_0000, 3'd0, 4'd5, 4, ok);
        check("add_push", 32'(ok), 32'd1);
        wait_rsp(n0 + 1, 100, "add_wait");
        check_rsps();
        check("add_result", obs_q[n0].res, 32'h4040_0000);
        check("add_tag", 32'(obs_q[n0].tag), 32'd5);
        check("add_starts", 32'(starts - s0), 32'd1);

        // divide by zero
        n0 = obs_q.size();
        push_cmd(32'h3F80_0000, 32'h0000_0000, 3'd3, 4'd9, 4, ok);
        wait_rsp(n0 + 1, 100, "div0_wait");
        check_rsps();
        check("div0_invalid", 32'(obs_q[n0].inv), 32'd1);
        check("div0_tag", 32'(obs_q[n0].tag), 32'd9);

        // random traffic with random response backpressure
        wait_idle(50, "rand_pre_idle");
        bp_mode = 1'b1;
        n0 = obs_q.size();
        s0 = starts;
        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(7, 0) == 0) ? 32'd0 : $urandom;
            push_cmd(ra, rb, 3'($urandom_range(3, 0)), 4'($urandom_range(15, 0)), 300, ok);
            check("rand_push", 32'(ok), 32'd1);
        end
        wait_idle(600, "rand_drain");
        check("rand_count", 32'(obs_q.size() - n0), 32'd24);
        check("rand_starts", 32'(starts - s0), 32'd24);
        bp_mode  = 1'b0;
        bp_level = 1'b1;

        // fill the FIFO while the ALU is held busy
        wait_idle(50, "fill_pre_idle");
        alu_hold = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n0 = obs_q.size();
        s0 = starts;
        for (int i = 0; i < DEPTH; i++) begin
            push_cmd($urandom, $urandom, 3'($urandom_range(2, 0)), 4'(i + 1), 2, ok);
            check("fill_push", 32'(ok), 32'd1);
        end
        check("fill_cmd_ready", 32'(cmd_ready), 32'd0);
        check("fill_busy", 32'(busy), 32'd1);
        push_cmd(32'h1234_5678, 32'h0BAD_F00D, 3'd1, 4'(DEPTH + 1), 4, ok);
        check("fill_reject", 32'(ok), 32'd0);
        check("fill_no_start", 32'(starts - s0), 32'd0);
        alu_hold = 1'b0;
        push_cmd(32'h1234_5678, 32'h0BAD_F00D, 3'd1, 4'(DEPTH + 1), 300, ok);
        check("fill_late_push", 32'(ok), 32'd1);
        wait_rsp(n0 + DEPTH + 1, 300, "fill_wait");
        check_rsps();

        // backpressure in RESP for 10 cycles
        wait_idle(50, "bp_pre_idle");
        bp_level = 1'b0;
        n0 = obs_q.size();
        s0 = starts;
        push_cmd(32'h4080_0000, 32'h3F00_0000, 3'd2, 4'd1, 4, ok);
        push_cmd(32'h4100_0000, 32'h4000_0000, 3'd1, 4'd2, 4, ok);
        got = rsp_valid;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk); #1;
            got = rsp_valid;
        end
        check("bp_valid_wait", 32'(got), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_valid_hold", 32'(rsp_valid), 32'd1);
            check("bp_result_hold", rsp_result, exp_q[n0].res);
            check("bp_tag_hold", 32'(rsp_tag), 32'(exp_q[n0].tag));
            check("bp_invalid_hold", 32'(rsp_invalid), 32'(exp_q[n0].inv));
        end
        check("bp_no_new_start", 32'(starts - s0), 32'd1);
        bp_level = 1'b1;
        wait_rsp(n0 + 1, 20, "bp_release_wait");
        hs  = last_hs_cyc;
        got = (starts - s0 >= 2);
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            got = (starts - s0 >= 2);
        end
        check("bp_next_start_wait", 32'(got), 32'd1);
        check("bp_issue_gap", 32'(last_start_cyc - hs), 32'd2);
        wait_rsp(n0 + 2, 100, "bp_second_wait");
        check_rsps();

        // ALU hangs: watchdog aborts
        wait_idle(50, "tmo_pre_idle");
        alu_hang = 1'b1;
        n0 = obs_q.size();
        s0 = starts;
        push_cmd(32'h3F80_0000, 32'h4040_0000, 3'd2, 4'd3, 4, ok);
        wait_rsp(n0 + 1, TIMEOUT + 60, "tmo_wait");
        check_rsps();
        check("tmo_result", obs_q[n0].res, QNAN);
        check("tmo_invalid", 32'(obs_q[n0].inv), 32'd1);
        check("tmo_latency", 32'(last_hs_cyc - last_start_cyc), 32'(TIMEOUT + 1));
        repeat (5) @(posedge clk);
        #1;
        check("tmo_err_sticky", 32'(err_timeout), 32'd1);
        check("tmo_single_start", 32'(starts - s0), 32'd1);
        alu_hang = 1'b0;
        do_reset();
        check("tmo_err_cleared", 32'(err_timeout), 32'd0);

        // reset while waiting for the ALU
        lat_min = 20;
        lat_max = 20;
        n0 = obs_q.size();
        s0 = starts;
        push_cmd(32'h4000_0000, 32'h4000_0000, 3'd0, 4'd7, 4, ok);
        got = (starts != s0);
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            got = (starts != s0);
        end
        check("rst_start_wait", 32'(got), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("rst_busy_before", 32'(busy), 32'd1);
        do_reset();
        check_reset_outputs("rst_mid");
        lat_min = 1;
        lat_max = 6;
        repeat (30) @(posedge clk);
        #1;
        check("rst_no_response", 32'(obs_q.size() - n0), 32'd0);
        push_cmd(32'h4040_0000, 32'h3F80_0000, 3'd1, 4'd12, 4, ok);
        wait_rsp(n0 + 1, 100, "rst_after_wait");
        check_rsps();

        wait_idle(50, "final_idle");
        check("final_balance", 32'(obs_q.size()), 32'(exp_q.size()));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_alu_dispatcher.md
FP_ALU_DISPATCHER -- requirements
Module: fp_alu_dispatcher

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO depth (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 32, max cycles waited in WAIT_DONE before abort.
REQ-003 SHALL have clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have cmd_valid  input  1  command offered.
REQ-006 SHALL have cmd_ready  output  1  FIFO can accept command (= not full).
REQ-007 SHALL have cmd_a, cmd_b  input  32 each  IEEE754 single operands.
REQ-008 SHALL have cmd_op  input  3  opcode (000 add, 001 sub, 010 mul, 011 div).
REQ-009 SHALL have cmd_tag  input  4  caller tag, returned with response.
REQ-010 SHALL have alu_start  output  1  start pulse to ALU.
REQ-011 SHALL have alu_operand_a, alu_operand_b  output  32 each; alu_opcode  output  3.
REQ-012 SHALL have alu_ready  input  1; alu_result  input  32; alu_invalid  input  1.
REQ-013 SHALL have rsp_valid  output  1; rsp_ready  input  1; rsp_result  output  32; rsp_invalid  output  1; rsp_tag  output  4.
REQ-014 SHALL have err_timeout  output  1  sticky abort flag; busy  output  1  (FIFO non-empty or state != IDLE).

Function
REQ-015 SHALL push cmd_{a,b,op,tag} into FIFO on cycle where cmd_valid && cmd_ready; cmd_ready SHALL be low when count == DEPTH.
REQ-016 SHALL pop FIFO only in IDLE; push and pop in same cycle SHALL leave count unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-017 SHALL implement FSM IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
REQ-018 IDLE: FIFO non-empty and alu_ready high -> pop head into hold registers, go ISSUE; otherwise stay.
REQ-019 ISSUE: alu_start high exactly this one cycle; go WAIT_BUSY.
REQ-020 WAIT_BUSY: alu_ready low -> WAIT_DONE; alu_start SHALL NOT re-assert.
REQ-021 WAIT_DONE: alu_ready high -> capture alu_result, alu_invalid into rsp regs, rsp_tag = held tag, go RESP.
REQ-022 alu_operand_a/b and alu_opcode SHALL be driven from hold registers and remain stable from ISSUE until exit of WAIT_DONE (ALU samples opcode several cycles after start).
REQ-023 Cycle counter SHALL clear on ISSUE and increment in WAIT_BUSY/WAIT_DONE; reaching TIMEOUT -> rsp_result = 32'h7FC00000, rsp_invalid = 1, err_timeout set, go RESP.
REQ-024 RESP: rsp_valid high; rsp_* stable while rsp_valid && !rsp_ready; rsp_valid && rsp_ready -> IDLE, rsp_valid low next cycle.
REQ-025 At most one operation outstanding at ALU; responses SHALL be returned in command order.
REQ-026 Back-to-back: after handshake in RESP, next ISSUE SHALL occur no earlier than 2 cycles later (IDLE then ISSUE).
REQ-027 err_timeout SHALL remain set until reset.

Reset
REQ-028 reset SHALL clear FIFO (count 0, pointers 0), state IDLE, counter 0.
REQ-029 Outputs after reset: cmd_ready 1, alu_start 0, alu_operand_a/b 0, alu_opcode 0, rsp_valid 0, rsp_result 0, rsp_invalid 0, rsp_tag 0, err_timeout 0, busy 0.
REQ-030 Reset mid-operation SHALL abandon in-flight op without response; next ISSUE SHALL wait for alu_ready high (REQ-018).

Verification
REQ-031 Single add: push a=3F800000, b=40000000, op 000, tag 5, with fp_alu attached -> one alu_start pulse; rsp_result 40400000, rsp_invalid 0, rsp_tag 5.
REQ-032 Fill: push DEPTH+1 commands with rsp_ready=1 and ALU held busy (alu_ready=0) -> cmd_ready low after DEPTH+... pushes accepted limited to DEPTH (hold pops excluded); no command lost; tags return in order.
REQ-033 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_* stable, no new alu_start, then release -> next op issued 2 cycles after handshake.
REQ-034 Divide by zero: a=3F800000, b=00000000, op 011 -> rsp_invalid 1, rsp_tag matches.
REQ-035 Timeout: ALU model drops alu_ready and never raises it -> after TIMEOUT cycles rsp_result 7FC00000, rsp_invalid 1, err_timeout 1.
REQ-036 Reset in WAIT_DONE -> all outputs at REQ-029 values next cycle, no response emitted.
